// File: rtl/bp_fe_ras_ctrl.sv
// Return address stack controller: turns call/return predictions into storage
// writes, tracks top-of-stack and occupancy, checkpoints/restores, and clears storage.
module bp_fe_ras_ctrl #(
  parameter int vaddr_width_p = 39,
  parameter int ras_els       = 8,
  parameter int ckpt_els      = 4,
  localparam int ptr_w = $clog2(ras_els),
  localparam int cnt_w = $clog2(ras_els + 1),
  localparam int cid_w = $clog2(ckpt_els)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     call_v_i,
  input  logic                     ret_v_i,
  input  logic [vaddr_width_p-1:0] call_addr_i,
  input  logic                     ckpt_v_i,
  input  logic [cid_w-1:0]         ckpt_id_i,
  input  logic                     restore_v_i,
  input  logic [cid_w-1:0]         restore_id_i,
  input  logic                     flush_v_i,
  output logic                     ready_o,
  output logic [vaddr_width_p-1:0] ret_addr_o,
  output logic                     ret_addr_v_o,
  output logic                     ras_w_v_o,
  output logic [ptr_w-1:0]         ras_w_addr_o,
  output logic [vaddr_width_p-1:0] ras_w_data_o,
  output logic [ptr_w-1:0]         ras_r_addr_o,
  input  logic [vaddr_width_p-1:0] ras_r_data_i,
  output logic [cnt_w-1:0]         count_o
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  localparam logic [ptr_w-1:0] tos_rst = ptr_w'(ras_els - 1);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(ras_els);

  state_e              state_q, state_d;
  logic [ptr_w-1:0]    tos_q, tos_d;
  logic [cnt_w-1:0]    count_q, count_d;
  logic [ptr_w-1:0]    clr_idx_q, clr_idx_d;
  logic [ckpt_els-1:0] ckpt_v_q, ckpt_v_d;
  logic [ptr_w-1:0]    ckpt_tos_q [ckpt_els];
  logic [ptr_w-1:0]    ckpt_tos_d [ckpt_els];
  logic [cnt_w-1:0]    ckpt_cnt_q [ckpt_els];
  logic [cnt_w-1:0]    ckpt_cnt_d [ckpt_els];
  logic                do_flush;

  // A restore that names an empty slot has nothing to return to, so it
  // degrades to a full flush.
  assign do_flush = flush_v_i || (restore_v_i && !ckpt_v_q[restore_id_i]);

  always_comb begin
    state_d      = state_q;
    tos_d        = tos_q;
    count_d      = count_q;
    clr_idx_d    = clr_idx_q;
    ckpt_v_d     = ckpt_v_q;
    ckpt_tos_d   = ckpt_tos_q;
    ckpt_cnt_d   = ckpt_cnt_q;
    ras_w_v_o    = 1'b0;
    ras_w_addr_o = tos_q;
    ras_w_data_o = '0;
    case (state_q)
      ST_CLEAR: begin
        ras_w_v_o    = 1'b1;
        ras_w_addr_o = clr_idx_q;
        clr_idx_d    = clr_idx_q + 1'b1;
        if (flush_v_i) begin
          clr_idx_d = '0;
          tos_d     = tos_rst;
          count_d   = '0;
          ckpt_v_d  = '0;
        end else if (clr_idx_q == tos_rst) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (do_flush) begin
          tos_d     = tos_rst;
          count_d   = '0;
          ckpt_v_d  = '0;
          clr_idx_d = '0;
          state_d   = ST_CLEAR;
        end else if (restore_v_i) begin
          tos_d                  = ckpt_tos_q[restore_id_i];
          count_d                = ckpt_cnt_q[restore_id_i];
          ckpt_v_d[restore_id_i] = 1'b0;
        end else begin
          // Checkpoint captures the state before this cycle's call/ret.
          if (ckpt_v_i) begin
            ckpt_v_d[ckpt_id_i]   = 1'b1;
            ckpt_tos_d[ckpt_id_i] = tos_q;
            ckpt_cnt_d[ckpt_id_i] = count_q;
          end
          if (call_v_i && ret_v_i) begin
            ras_w_v_o    = 1'b1;
            ras_w_addr_o = tos_q;
            ras_w_data_o = call_addr_i;
            if (count_q == '0) count_d = cnt_w'(1);
          end else if (call_v_i) begin
            ras_w_v_o    = 1'b1;
            ras_w_addr_o = tos_q + 1'b1;
            ras_w_data_o = call_addr_i;
            tos_d        = tos_q + 1'b1;
            if (count_q != cnt_max) count_d = count_q + 1'b1;
          end else if (ret_v_i && (count_q != '0)) begin
            tos_d   = tos_q - 1'b1;
            count_d = count_q - 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_CLEAR;
      tos_q     <= tos_rst;
      count_q   <= '0;
      clr_idx_q <= '0;
      ckpt_v_q  <= '0;
    end else begin
      state_q   <= state_d;
      tos_q     <= tos_d;
      count_q   <= count_d;
      clr_idx_q <= clr_idx_d;
      ckpt_v_q  <= ckpt_v_d;
    end
  end

  // Slot payloads are only meaningful behind their valid bit.
  always_ff @(posedge clk_i) begin
    ckpt_tos_q <= ckpt_tos_d;
    ckpt_cnt_q <= ckpt_cnt_d;
  end

  assign ready_o      = (state_q == ST_IDLE);
  assign ret_addr_o   = ras_r_data_i;
  assign ret_addr_v_o = ready_o && (count_q != '0);
  assign ras_r_addr_o = tos_q;
  assign count_o      = count_q;

endmodule

// File: doc/bp_fe_ras_ctrl.md
Name: bp_fe_ras_ctrl

Overview:
Controller for the front-end return address stack storage (a bank of ras_els enabled registers with one write port and one combinational read port). It turns fetch-side call/return predictions into push/pop/replace commands and keeps the top-of-stack pointer and occupancy. It checkpoints stack state per in-flight branch and restores it on backend redirect. It sequences a multi-cycle clear of the storage after reset or flush.

Parameters:
vaddr_width_p, 39, width of a return address
ras_els, 8, stack entries; power of two, >= 2
ckpt_els, 4, checkpoint slots; power of two, >= 2

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous, active-low reset
call_v_i  in  1  fetch predicts a call this cycle
ret_v_i  in  1  fetch predicts a return this cycle
call_addr_i  in  vaddr_width_p  return address to push on call
ckpt_v_i  in  1  save a checkpoint this cycle
ckpt_id_i  in  $clog2(ckpt_els)  checkpoint slot to write
restore_v_i  in  1  backend redirect; restore from a checkpoint
restore_id_i  in  $clog2(ckpt_els)  checkpoint slot to restore
flush_v_i  in  1  discard all stack and checkpoint state
ready_o  out  1  controller accepts call/ret/ckpt this cycle
ret_addr_o  out  vaddr_width_p  predicted return address (top of stack)
ret_addr_v_o  out  1  ret_addr_o is meaningful
ras_w_v_o  out  1  storage write enable
ras_w_addr_o  out  $clog2(ras_els)  storage write index
ras_w_data_o  out  vaddr_width_p  storage write data
ras_r_addr_o  out  $clog2(ras_els)  storage read index; equals tos
ras_r_data_i  in  vaddr_width_p  storage read data, combinational
count_o  out  $clog2(ras_els+1)  current occupancy

Behaviour:
- State: tos (ptr width), count (0..ras_els), FSM {CLEAR, IDLE}, clr_idx (ptr width), ckpt table of ckpt_els x {valid, tos, count}.
- Reset (reset_n_i=0 at clk edge):
  - tos=ras_els-1, count=0, all ckpt valid=0, clr_idx=0, state=CLEAR.
  - Outputs after reset: ready_o=0, ret_addr_v_o=0, count_o=0.
- CLEAR:
  - Each cycle: ras_w_v_o=1, ras_w_addr_o=clr_idx, ras_w_data_o=0, clr_idx++.
  - After the write to index ras_els-1, go to IDLE. Clear lasts exactly ras_els cycles; ready_o is high on cycle ras_els+1 after reset release.
  - call/ret/ckpt/restore are ignored in CLEAR.
  - flush_v_i during CLEAR restarts clr_idx=0.
- IDLE: ready_o=1, ret_addr_o=ras_r_data_i, ret_addr_v_o=(count!=0), ras_r_addr_o=tos.
- IDLE event priority, highest first: flush, restore, call/ret.
  - flush_v_i: tos=ras_els-1, count=0, clear all ckpt valid, clr_idx=0, go to CLEAR.
  - restore_v_i with valid slot: load tos/count from the slot; clear that slot's valid. call/ret/ckpt in the same cycle are dropped.
  - restore_v_i with invalid slot: treated as flush.
  - call only (push): write call_addr_i at tos+1 (mod ras_els); tos=tos+1; count=min(count+1, ras_els). A push at full overwrites the oldest entry; count stays ras_els.
  - ret only (pop): if count>0 then tos=tos-1 (mod), count--. If count==0 (underflow), tos and count are unchanged and nothing is written.
  - call and ret together (replace): write call_addr_i at tos; tos unchanged; count=max(count,1).
- Checkpoint: ckpt_v_i in IDLE (not overridden by flush/restore) stores the pre-update {tos,count} in slot ckpt_id_i and sets its valid bit. Overwriting a valid slot is allowed.
- Write port: ras_w_v_o is 0 when there is no push, replace or clear.
- Storage write and tos update take effect at the same edge. The next cycle's ret_addr_o shows the new top.

Test Plan:
- Reset: hold reset_n_i=0 for 2 cycles, release -> ready_o=0 and ras_w_v_o=1 with addrs 0..7 and data 0 for 8 cycles; then ready_o=1, count_o=0, ret_addr_v_o=0.
- Push/pop: push 0x100, 0x200, 0x300 -> ret_addr_o=0x300, count_o=3; pop -> 0x200; pop twice -> count_o=0, ret_addr_v_o=0; one more pop -> count_o stays 0, no write.
- Overflow: 9 pushes of 0x10..0x90 -> count_o=8, ret_addr_o=0x90; 7 pops -> ret_addr_o=0x20 (0x10 was overwritten).
- Replace: with 0xA0 on top, assert call and ret together with 0xB0 -> ret_addr_o=0xB0, count_o unchanged, ras_w_addr_o equals the prior tos.
- Checkpoint/restore: push 0x100, ckpt slot 2, push 0x200, 0x300, restore slot 2 -> ret_addr_o=0x100, count_o=1. Restore slot 2 again -> flush (CLEAR for 8 cycles).
- Collisions: restore, call and flush in the same IDLE cycle -> flush wins, count_o=0. Flush mid-CLEAR at clr_idx=5 -> clear restarts at 0 and runs 8 more cycles.
